// File: rtl/pulse_cmd_pkg.sv
// Shared constants for the pulse command controller: opcodes, frame sizing and frame FSM states.
package pulse_cmd_pkg;

  localparam int         PAYLOAD_BYTES = 4;
  localparam logic [7:0] ACK_ERR       = 8'hFF;

  localparam logic [7:0] CONT_SET_DELAY     = 8'd0;
  localparam logic [7:0] CONT_SET_PERIOD    = 8'd1;
  localparam logic [7:0] CONT_SET_PULSE1    = 8'd2;
  localparam logic [7:0] CONT_SET_PULSE2    = 8'd3;
  localparam logic [7:0] CONT_TOGGLE_PULSE1 = 8'd4;
  localparam logic [7:0] CONT_SET_CPMG      = 8'd5;
  localparam logic [7:0] CONT_SET_ATT       = 8'd6;
  localparam logic [7:0] CONT_SET_NUTW      = 8'd7;
  localparam logic [7:0] CONT_SET_NUTD      = 8'd8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_COMMIT  = 2'd2
  } frame_state_e;

  function automatic logic opcode_known(input logic [7:0] op);
    return op <= CONT_SET_NUTD;
  endfunction

endpackage

// File: rtl/pulse_cmd_frame.sv
// Byte assembler: opcode plus little-endian payload, with an inter-byte idle timeout.
// state      | meaning
// ST_IDLE    | waiting for an opcode byte
// ST_PAYLOAD | collecting payload bytes, gap timer running
// ST_COMMIT  | frame complete for one cycle; a byte here opens the next frame
module pulse_cmd_frame
  import pulse_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  opcode_o,
  output logic [31:0] payload_o,
  output logic        frame_done_o,
  output logic        timeout_o
);

  localparam int               GAP_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(TIMEOUT_CYC - 1);
  localparam logic [1:0]       LAST_BYTE = 2'(PAYLOAD_BYTES - 1);

  frame_state_e             state_q;
  logic [1:0]               cnt_q;
  logic [GAP_W-1:0]         gap_q;
  logic [7:0]               opcode_q;
  logic [PAYLOAD_BYTES*8-1:0] payload_q;
  logic                     done_q;
  logic                     timeout_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      gap_q     <= '0;
      opcode_q  <= '0;
      payload_q <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_COMMIT: begin
          if (rx_valid_i) begin
            opcode_q <= rx_data_i;
            cnt_q    <= '0;
            gap_q    <= GAP_LOAD;
            state_q  <= ST_PAYLOAD;
          end else begin
            state_q  <= ST_IDLE;
          end
        end
        ST_PAYLOAD: begin
          if (rx_valid_i) begin
            payload_q[{cnt_q, 3'b000} +: 8] <= rx_data_i;
            cnt_q <= cnt_q + 2'd1;
            gap_q <= GAP_LOAD;
            if (cnt_q == LAST_BYTE) begin
              state_q <= ST_COMMIT;
              done_q  <= 1'b1;
            end
          end else if (gap_q == '0) begin
            // Partial frame is dropped; stale payload bytes are fully overwritten by the next frame.
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign opcode_o     = opcode_q;
  assign payload_o    = payload_q;
  assign frame_done_o = done_q;
  assign timeout_o    = timeout_q;

endmodule

// File: rtl/pulse_cmd_ctrl.sv
// Command decoder with shadow/live configuration registers applied at pulse-period boundaries.
// Optional acknowledge byte to the UART transmitter is enabled by defining PULSE_CMD_ACK_EN.
module pulse_cmd_ctrl
  import pulse_cmd_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                TIMEOUT_CYC  = 100000,
  parameter logic [DATA_W-1:0] RESET_PERIOD = 32'd1000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              period_start,
  input  logic              gen_idle,
  output logic [DATA_W-1:0] delay_out,
  output logic [DATA_W-1:0] period_out,
  output logic [DATA_W-1:0] pulse1_out,
  output logic [DATA_W-1:0] pulse2_out,
  output logic              pulse1_en,
  output logic [7:0]        cpmg_out,
  output logic [7:0]        att_out,
  output logic [DATA_W-1:0] nutw_out,
  output logic [DATA_W-1:0] nutd_out,
  output logic              cfg_pending,
  output logic              frame_err,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  logic [7:0]  opcode;
  logic [31:0] payload;
  logic        commit, timeout, known, apply, ack_overwrite;
  logic        cfg_pending_q, cfg_pending_d, frame_err_q;
  logic [DATA_W-1:0] payload_w;

  logic [DATA_W-1:0] sh_delay_q, sh_period_q, sh_pulse1_q, sh_pulse2_q, sh_nutw_q, sh_nutd_q;
  logic [DATA_W-1:0] delay_q, period_q, pulse1_q, pulse2_q, nutw_q, nutd_q;
  logic [7:0]        sh_cpmg_q, sh_att_q, cpmg_q, att_q;
  logic              sh_p1en_q, p1en_q;

  pulse_cmd_frame #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_frame (
    .clk          (clk),
    .resetn       (resetn),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .opcode_o     (opcode),
    .payload_o    (payload),
    .frame_done_o (commit),
    .timeout_o    (timeout)
  );

  always_comb begin
    known     = opcode_known(opcode);
    payload_w = DATA_W'(payload);
    apply     = cfg_pending_q && (period_start || gen_idle);
    cfg_pending_d = cfg_pending_q;
    if (apply)            cfg_pending_d = 1'b0;
    // A commit in the apply cycle keeps the new value staged for the following boundary.
    if (commit && known)  cfg_pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sh_delay_q  <= '0;
      sh_period_q <= RESET_PERIOD;
      sh_pulse1_q <= '0;
      sh_pulse2_q <= '0;
      sh_p1en_q   <= 1'b1;
      sh_cpmg_q   <= '0;
      sh_att_q    <= '0;
      sh_nutw_q   <= '0;
      sh_nutd_q   <= '0;
    end else if (commit && known) begin
      case (opcode)
        CONT_SET_DELAY:     sh_delay_q  <= payload_w;
        CONT_SET_PERIOD:    sh_period_q <= payload_w;
        CONT_SET_PULSE1:    sh_pulse1_q <= payload_w;
        CONT_SET_PULSE2:    sh_pulse2_q <= payload_w;
        CONT_TOGGLE_PULSE1: sh_p1en_q   <= ~sh_p1en_q;
        CONT_SET_CPMG:      sh_cpmg_q   <= payload[7:0];
        CONT_SET_ATT:       sh_att_q    <= payload[7:0];
        CONT_SET_NUTW:      sh_nutw_q   <= payload_w;
        CONT_SET_NUTD:      sh_nutd_q   <= payload_w;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      delay_q  <= '0;
      period_q <= RESET_PERIOD;
      pulse1_q <= '0;
      pulse2_q <= '0;
      p1en_q   <= 1'b1;
      cpmg_q   <= '0;
      att_q    <= '0;
      nutw_q   <= '0;
      nutd_q   <= '0;
    end else if (apply) begin
      delay_q  <= sh_delay_q;
      period_q <= sh_period_q;
      pulse1_q <= sh_pulse1_q;
      pulse2_q <= sh_pulse2_q;
      p1en_q   <= sh_p1en_q;
      cpmg_q   <= sh_cpmg_q;
      att_q    <= sh_att_q;
      nutw_q   <= sh_nutw_q;
      nutd_q   <= sh_nutd_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cfg_pending_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      cfg_pending_q <= cfg_pending_d;
      if (timeout || (commit && !known) || ack_overwrite) frame_err_q <= 1'b1;
    end
  end

`ifdef PULSE_CMD_ACK_EN
  logic [7:0] tx_data_q;
  logic       tx_valid_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else if (commit) begin
      tx_data_q  <= known ? opcode : ACK_ERR;
      tx_valid_q <= 1'b1;
    end else if (tx_valid_q && tx_ready) begin
      tx_valid_q <= 1'b0;
    end
  end

  // Only an ack that is not being accepted this cycle is lost.
  assign ack_overwrite = commit && tx_valid_q && !tx_ready;
  assign tx_data       = tx_data_q;
  assign tx_valid      = tx_valid_q;
`else
  logic unused_tx_ready;
  assign unused_tx_ready = tx_ready;
  assign ack_overwrite   = 1'b0;
  assign tx_data         = 8'h00;
  assign tx_valid        = 1'b0;
`endif

  assign delay_out   = delay_q;
  assign period_out  = period_q;
  assign pulse1_out  = pulse1_q;
  assign pulse2_out  = pulse2_q;
  assign pulse1_en   = p1en_q;
  assign cpmg_out    = cpmg_q;
  assign att_out     = att_q;
  assign nutw_out    = nutw_q;
  assign nutd_out    = nutd_q;
  assign cfg_pending = cfg_pending_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_pulse_cmd_ctrl.sv
// Bench for pulse_cmd_ctrl: table-driven opcode vectors, directed corner sequences and a random run against a reference model.
module tb_pulse_cmd_ctrl;

  localparam int TO = 40;

  logic        clk = 1'b0, resetn = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0, period_start = 1'b0, gen_idle = 1'b0, tx_ready = 1'b1;
  logic [31:0] delay_out, period_out, pulse1_out, pulse2_out, nutw_out, nutd_out;
  logic        pulse1_en, cfg_pending, frame_err, tx_valid;
  logic [7:0]  cpmg_out, att_out, tx_data;

  int n_checks = 0;
  int n_fail   = 0;

  pulse_cmd_ctrl #(.DATA_W(32), .TIMEOUT_CYC(TO), .RESET_PERIOD(32'd1000)) dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .period_start(period_start), .gen_idle(gen_idle),
    .delay_out(delay_out), .period_out(period_out), .pulse1_out(pulse1_out),
    .pulse2_out(pulse2_out), .pulse1_en(pulse1_en), .cpmg_out(cpmg_out),
    .att_out(att_out), .nutw_out(nutw_out), .nutd_out(nutd_out),
    .cfg_pending(cfg_pending), .frame_err(frame_err),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] pay);
    send_byte(op);
    for (int i = 0; i < 4; i++) send_byte(pay[8*i +: 8]);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  function automatic logic [255:0] dut_vec();
    return {delay_out, period_out, pulse1_out, pulse2_out, nutw_out, nutd_out,
            pulse1_en, cpmg_out, att_out, cfg_pending, frame_err};
  endfunction

  function automatic logic [31:0] out_sel(input logic [7:0] op);
    case (op)
      8'd0: return delay_out;
      8'd1: return period_out;
      8'd2: return pulse1_out;
      8'd3: return pulse2_out;
      8'd4: return {31'd0, pulse1_en};
      8'd5: return {24'd0, cpmg_out};
      8'd6: return {24'd0, att_out};
      8'd7: return nutw_out;
      default: return nutd_out;
    endcase
  endfunction

  // Reference model: configuration indexed by opcode, a byte list for the open frame.
  int unsigned m_live[9], m_shadow[9];
  bit          m_pending, m_err, m_cstage;
  byte unsigned m_q[$];
  byte unsigned m_cop;
  int unsigned m_cpay;

  function automatic void model_reset();
    m_live    = '{0, 1000, 0, 0, 1, 0, 0, 0, 0};
    m_shadow  = m_live;
    m_pending = 0;
    m_err     = 0;
    m_cstage  = 0;
    m_q.delete();
  endfunction

  function automatic void model_step(input bit rxv, input byte unsigned rxd, input bit ps, input bit gi);
    bit apply;
    bit nxt_pending;
    int unsigned nxt_live[9];
    apply = m_pending && (ps || gi);
    nxt_live = apply ? m_shadow : m_live;
    nxt_pending = apply ? 1'b0 : m_pending;
    if (m_cstage) begin
      if (m_cop <= 8) begin
        if (m_cop == 4)                   m_shadow[4] = m_shadow[4] ^ 1;
        else if (m_cop == 5 || m_cop == 6) m_shadow[m_cop] = m_cpay % 256;
        else                              m_shadow[m_cop] = m_cpay;
        nxt_pending = 1;
      end else begin
        m_err = 1;
      end
    end
    m_live    = nxt_live;
    m_pending = nxt_pending;
    m_cstage  = 0;
    if (rxv) begin
      m_q.push_back(rxd);
      if (m_q.size() == 5) begin
        m_cop   = m_q[0];
        m_cpay  = m_q[1] + 256 * m_q[2] + 65536 * m_q[3] + 16777216 * m_q[4];
        m_cstage = 1;
        m_q.delete();
      end
    end
  endfunction

  function automatic logic [255:0] model_vec();
    return {m_live[0], m_live[1], m_live[2], m_live[3], m_live[7], m_live[8],
            1'(m_live[4]), 8'(m_live[5]), 8'(m_live[6]), m_pending, m_err};
  endfunction

  task automatic rand_cycle(input bit rxv, input logic [7:0] rxd, input bit gi);
    rx_valid     = rxv;
    rx_data      = rxd;
    gen_idle     = gi;
    period_start = ($urandom_range(0, 7) == 0);
    @(posedge clk);
    model_step(rxv, rxd, period_start, gi);
    #1;
    rx_valid     = 1'b0;
    period_start = 1'b0;
    check("random", dut_vec(), model_vec());
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] pay;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[9];
  logic [255:0] reset_vec;

  initial begin
    reset_vec = {32'd0, 32'd1000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0};
    tbl[0] = '{8'd0, 32'h0000_01F4, 32'd500};
    tbl[1] = '{8'd1, 32'd10000,     32'd10000};
    tbl[2] = '{8'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[3] = '{8'd3, 32'd33,        32'd33};
    tbl[4] = '{8'd4, 32'hFFFF_FFFF, 32'd0};
    tbl[5] = '{8'd5, 32'h1234_5607, 32'h07};
    tbl[6] = '{8'd6, 32'h0000_01AB, 32'hAB};
    tbl[7] = '{8'd7, 32'h8000_0001, 32'h8000_0001};
    tbl[8] = '{8'd8, 32'h0001_0000, 32'h0001_0000};

    do_reset();
    check("reset_outputs", dut_vec(), reset_vec);
    check("reset_tx_valid", 256'(tx_valid), 256'd0);

    // Opcode table with gen_idle high: value live two edges after the last byte.
    gen_idle = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send_frame(tbl[i].op, tbl[i].pay);
      tick();
      tick();
      check($sformatf("table_op%0d", tbl[i].op), 256'(out_sel(tbl[i].op)), 256'(tbl[i].exp));
      check($sformatf("table_pending%0d", tbl[i].op), 256'(cfg_pending), 256'd0);
    end

    // Staged period waits for period_start.
    do_reset();
    gen_idle = 1'b0;
    send_frame(8'd1, 32'd10000);
    repeat (3) tick();
    check("period_held", 256'(period_out), 256'd1000);
    check("period_pending", 256'(cfg_pending), 256'd1);
    period_start = 1'b1;
    tick();
    period_start = 1'b0;
    check("period_applied", 256'(period_out), 256'd10000);
    check("period_pending_clr", 256'(cfg_pending), 256'd0);

    // Commit coincident with a boundary.
    do_reset();
    gen_idle = 1'b0;
    send_frame(8'd2, 32'd20);
    tick();
    send_frame(8'd2, 32'd30);
    period_start = 1'b1;
    tick();
    period_start = 1'b0;
    check("coinc_live_old", 256'(pulse1_out), 256'd20);
    check("coinc_still_pending", 256'(cfg_pending), 256'd1);
    repeat (2) tick();
    check("coinc_hold", 256'(pulse1_out), 256'd20);
    period_start = 1'b1;
    tick();
    period_start = 1'b0;
    check("coinc_live_new", 256'(pulse1_out), 256'd30);
    check("coinc_pending_clr", 256'(cfg_pending), 256'd0);

    // Timeout on a partial frame.
    do_reset();
    gen_idle = 1'b1;
    send_frame(8'd2, 32'd7);
    tick();
    tick();
    check("to_pre_pulse1", 256'(pulse1_out), 256'd7);
    send_byte(8'h02);
    send_byte(8'h05);
    repeat (TO - 1) tick();
    check("to_not_yet", 256'(frame_err), 256'd0);
    repeat (2) tick();
    check("to_frame_err", 256'(frame_err), 256'd1);
    check("to_pulse1_kept", 256'(pulse1_out), 256'd7);
    send_frame(8'd2, 32'd99);
    tick();
    tick();
    check("to_recover", 256'(pulse1_out), 256'd99);

    // Unknown opcode.
    do_reset();
    gen_idle = 1'b1;
    tx_ready = 1'b0;
    send_frame(8'h0C, 32'h1122_3344);
    tick();
    tick();
    check("unk_regs", {dut_vec()[255:1], 1'b0}, {reset_vec[255:1], 1'b0});
    check("unk_frame_err", 256'(frame_err), 256'd1);
`ifdef PULSE_CMD_ACK_EN
    check("unk_tx_data", 256'(tx_data), 256'hFF);
    check("unk_tx_valid", 256'(tx_valid), 256'd1);
    repeat (3) tick();
    check("unk_tx_held", 256'(tx_valid), 256'd1);
    tx_ready = 1'b1;
    tick();
    check("unk_tx_done", 256'(tx_valid), 256'd0);
`else
    check("unk_tx_valid_tied", 256'(tx_valid), 256'd0);
    check("unk_tx_data_tied", 256'(tx_data), 256'd0);
`endif
    tx_ready = 1'b1;

    // Two toggles.
    do_reset();
    gen_idle = 1'b1;
    send_frame(8'd4, 32'd0);
    tick();
    tick();
    check("toggle_1", 256'(pulse1_en), 256'd0);
    send_frame(8'd4, 32'd0);
    tick();
    tick();
    check("toggle_2", 256'(pulse1_en), 256'd1);

    // Asynchronous reset mid-frame, with a staged value outstanding.
    do_reset();
    gen_idle = 1'b1;
    send_frame(8'd0, 32'd123);
    send_frame(8'd1, 32'd456);
    tick();
    tick();
    check("pre_rst_delay", 256'(delay_out), 256'd123);
    gen_idle = 1'b0;
    send_frame(8'd3, 32'd77);
    send_byte(8'h07);
    send_byte(8'h55);
    #2 resetn = 1'b0;
    #1;
    check("async_reset", dut_vec(), reset_vec);
    #2 resetn = 1'b1;
    gen_idle = 1'b1;
    tick();
    tick();
    check("async_shadow_clr", 256'(pulse2_out), 256'd0);
    send_frame(8'd3, 32'd66);
    tick();
    tick();
    check("async_realign", 256'(pulse2_out), 256'd66);

    // Random frames against the model.
    do_reset();
    model_reset();
    for (int f = 0; f < 60; f++) begin
      logic [7:0]  op;
      logic [31:0] pay;
      bit          gi;
      op  = 8'($urandom_range(0, 8));
      pay = $urandom;
      gi  = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < 5; b++) begin
        int gap;
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) rand_cycle(1'b0, 8'h00, gi);
        rand_cycle(1'b1, (b == 0) ? op : pay[8*(b-1) +: 8], gi);
      end
    end
    for (int k = 0; k < 10; k++) rand_cycle(1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) rand_cycle(1'b0, 8'h00, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
